// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - status bit map and sizing helpers shared by the I/O stream bridge
package io_bridge_pkg;
  localparam int ST_TXCNT_LSB = 0;
  localparam int ST_RXCNT_LSB = 8;
  localparam int ST_TX_OVF    = 16;
  localparam int ST_TX_BUSY   = 17;
  localparam int ST_RX_OVF    = 18;

  // Never returns 0, so pointer and index widths stay legal for size-1 cases.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [7:0] sat8(input int unsigned value);
    return (value > 255) ? 8'd255 : 8'(value);
  endfunction
endpackage

// File: rtl/io_stream_bridge_fifo.sv
// rtl/io_stream_bridge_fifo.sv - synchronous FIFO with registered count and a multi-entry head peek
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PEEK  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic [clog2(DEPTH):0]     pop_count,
  output logic [PEEK*WIDTH-1:0]     head,
  output logic [clog2(DEPTH):0]     count,
  output logic                      full
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  // A pop asking for more entries than are stored is ignored rather than underflowing.
  assign do_pop  = pop & (count >= pop_count);

  always_comb begin
    head = '0;
    for (int i = 0; i < PEEK; i++)
      head[i*WIDTH +: WIDTH] = mem[rd_ptr + AW'(i)];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + pop_count[AW-1:0];
      count <= count + CW'(do_push) - (do_pop ? pop_count : '0);
    end
  end
endmodule

// File: rtl/io_stream_bridge.sv
// rtl/io_stream_bridge.sv - buffered bridge between the core I/O port and a byte-wide UART stream
module io_stream_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int RX_WORD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_issued,
  input  logic [DATA_W-1:0] out_data,
  output logic              out_stall,
  input  logic              in_issued,
  output logic [DATA_W-1:0] in_data,
  output logic              in_stall,
  output logic [31:0]       status,
  output logic [31:0]       result_bytes,
  input  logic              clr_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);
  localparam int BPW  = bytes_per_word(DATA_W);
  localparam int IW   = clog2(BPW);
  localparam int TCW  = clog2(TX_DEPTH) + 1;
  localparam int RCW  = clog2(RX_DEPTH) + 1;
  localparam int NEED = (RX_WORD != 0) ? BPW : 1;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic [TCW-1:0]    tx_count;
  logic              loaded, tx_accept, tx_last;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              tx_ovf, rx_ovf;
  logic              rx_push, rx_pop, rx_full;
  logic [DATA_W-1:0] rx_head;
  logic [RCW-1:0]    rx_count;

  assign tx_push   = out_issued & ~tx_full;
  assign out_stall = tx_full;
  assign tx_empty  = (tx_count == '0);
  assign tx_valid  = loaded;
  assign tx_data   = shreg[7:0];
  assign tx_accept = loaded & tx_ready;
  assign tx_last   = (idx == IW'(BPW - 1));
  // Reloading on the last byte's handshake keeps the byte stream gap-free across words.
  assign tx_pop    = ~tx_empty & (~loaded | (tx_accept & tx_last));

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH), .PEEK(1)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (out_data),
    .pop       (tx_pop),
    .pop_count (TCW'(1)),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded       <= 1'b0;
      idx          <= '0;
      shreg        <= '0;
      result_bytes <= '0;
    end else begin
      if (tx_accept) result_bytes <= result_bytes + 32'd1;
      if (tx_pop) begin
        loaded <= 1'b1;
        idx    <= '0;
        shreg  <= tx_head;
      end else if (tx_accept) begin
        if (tx_last) begin
          loaded <= 1'b0;
          idx    <= '0;
          shreg  <= '0;
        end else begin
          idx   <= idx + 1'b1;
          shreg <= shreg >> 8;
        end
      end
    end
  end

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & ~rx_full;
  assign in_stall = (rx_count < RCW'(NEED));
  assign rx_pop   = in_issued & ~in_stall;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH), .PEEK(BPW)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_count (RCW'(NEED)),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full)
  );

  always_comb begin
    in_data = '0;
    if (!in_stall) in_data = (RX_WORD != 0) ? rx_head : DATA_W'(rx_head[7:0]);
  end

  // Sticky errors: a new event in the same cycle as clr_err keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (out_issued & tx_full) tx_ovf <= 1'b1;
      else if (clr_err)         tx_ovf <= 1'b0;
      if (rx_valid & rx_full)   rx_ovf <= 1'b1;
      else if (clr_err)         rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[ST_TXCNT_LSB +: 8] = sat8(32'(tx_count));
    status[ST_RXCNT_LSB +: 8] = sat8(32'(rx_count));
    status[ST_TX_OVF]         = tx_ovf;
    status[ST_TX_BUSY]        = loaded | ~tx_empty;
    status[ST_RX_OVF]         = rx_ovf;
  end
endmodule
